// File: rtl/regfile_checker.sv
// End-of-run checker: shadows a register-file window from the writeback port,
// freezes it at CHECK_CYCLE and compares it serially against an arithmetic sequence.
// Optional feature macro: RFCHK_UNWRITTEN_EN (never-written registers fail).
module regfile_checker #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int NUM_CHECK   = 8,
   parameter int BASE_REG    = 8,
   parameter int EXP_BASE    = 4,
   parameter int EXP_STEP    = 4,
   parameter int CHECK_CYCLE = 14,
   parameter int CYC_W       = 32,
   localparam int FF_W       = $clog2(NUM_CHECK) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 wb_en_i,
   input  logic [ADDR_W-1:0]    wb_addr_i,
   input  logic [DATA_W-1:0]    wb_data_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [NUM_CHECK-1:0] fail_mask_o,
   output logic [FF_W-1:0]      first_fail_o,
   output logic [DATA_W-1:0]    mismatch_data_o,
   output logic [CYC_W-1:0]     cycle_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CYC_W-1:0]      cycle_q, cycle_d;
   logic [FF_W-1:0]       idx_q, idx_d;
   logic [DATA_W-1:0]     shadow_q [NUM_CHECK];
   logic [DATA_W-1:0]     shadow_d [NUM_CHECK];
   logic [NUM_CHECK-1:0]  fail_mask_q, fail_mask_d;
   logic [FF_W-1:0]       first_fail_q, first_fail_d;
   logic [DATA_W-1:0]     mismatch_q, mismatch_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic [DATA_W-1:0]     cur_val_s;
   logic                  cur_fail_s;
`ifdef RFCHK_UNWRITTEN_EN
   logic [NUM_CHECK-1:0]  written_q, written_d;
   logic                  cur_wr_s;
`endif

   function automatic logic [DATA_W-1:0] exp_val(input logic [FF_W-1:0] idx);
      return DATA_W'(EXP_BASE) + DATA_W'(idx) * DATA_W'(EXP_STEP);
   endfunction

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cycle_q      <= '0;
         idx_q        <= '0;
         fail_mask_q  <= '0;
         first_fail_q <= '1;
         mismatch_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         for (int i = 0; i < NUM_CHECK; i++) shadow_q[i] <= '0;
`ifdef RFCHK_UNWRITTEN_EN
         written_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cycle_q      <= cycle_d;
         idx_q        <= idx_d;
         fail_mask_q  <= fail_mask_d;
         first_fail_q <= first_fail_d;
         mismatch_q   <= mismatch_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         for (int i = 0; i < NUM_CHECK; i++) shadow_q[i] <= shadow_d[i];
`ifdef RFCHK_UNWRITTEN_EN
         written_q    <= written_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) state_d = S_RUN;
            else         state_d = state_q;
         end
         S_RUN: begin
            if (cycle_q == CYC_W'(CHECK_CYCLE)) state_d = S_CHECK;
            else                                state_d = S_RUN;
         end
         S_CHECK: begin
            if (idx_q == FF_W'(NUM_CHECK - 1)) state_d = S_DONE;
            else                               state_d = S_CHECK;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      cycle_d      = cycle_q;
      idx_d        = idx_q;
      fail_mask_d  = fail_mask_q;
      first_fail_d = first_fail_q;
      mismatch_d   = mismatch_q;
      for (int i = 0; i < NUM_CHECK; i++) shadow_d[i] = shadow_q[i];
      cur_val_s    = '0;
`ifdef RFCHK_UNWRITTEN_EN
      written_d    = written_q;
      cur_wr_s     = 1'b0;
`endif
      for (int i = 0; i < NUM_CHECK; i++) begin
         if (idx_q == FF_W'(i)) begin
            cur_val_s = shadow_q[i];
`ifdef RFCHK_UNWRITTEN_EN
            cur_wr_s  = written_q[i];
`endif
         end else begin
            cur_val_s = cur_val_s;
         end
      end
`ifdef RFCHK_UNWRITTEN_EN
      cur_fail_s = !cur_wr_s || (cur_val_s != exp_val(idx_q));
`else
      cur_fail_s = (cur_val_s != exp_val(idx_q));
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               cycle_d      = CYC_W'(1);
               idx_d        = '0;
               fail_mask_d  = '0;
               first_fail_d = '1;
               mismatch_d   = '0;
               for (int i = 0; i < NUM_CHECK; i++) shadow_d[i] = '0;
`ifdef RFCHK_UNWRITTEN_EN
               written_d    = '0;
`endif
            end else begin
               cycle_d = cycle_q;
            end
         end
         S_RUN: begin
            cycle_d = (cycle_q == {CYC_W{1'b1}}) ? cycle_q : cycle_q + CYC_W'(1);
            for (int i = 0; i < NUM_CHECK; i++) begin
               if (wb_en_i && (wb_addr_i != '0) && (int'(wb_addr_i) == BASE_REG + i)) begin
                  shadow_d[i]  = wb_data_i;
`ifdef RFCHK_UNWRITTEN_EN
                  written_d[i] = 1'b1;
`endif
               end else begin
                  shadow_d[i] = shadow_d[i];
               end
            end
         end
         S_CHECK: begin
            cycle_d = (cycle_q == {CYC_W{1'b1}}) ? cycle_q : cycle_q + CYC_W'(1);
            idx_d   = idx_q + FF_W'(1);
            if (cur_fail_s) begin
               for (int i = 0; i < NUM_CHECK; i++) begin
                  if (idx_q == FF_W'(i)) fail_mask_d[i] = 1'b1;
                  else                   fail_mask_d[i] = fail_mask_d[i];
               end
               // Only the lowest failing index is reported in detail
               if (fail_mask_q == '0) begin
                  first_fail_d = idx_q;
`ifdef RFCHK_UNWRITTEN_EN
                  mismatch_d   = cur_wr_s ? cur_val_s : '0;
`else
                  mismatch_d   = cur_val_s;
`endif
               end else begin
                  first_fail_d = first_fail_q;
               end
            end else begin
               fail_mask_d = fail_mask_q;
            end
         end
         default: cycle_d = cycle_q;
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_CHECK);
      done_d = (state_q == S_DONE) && (state_d == S_DONE);
      pass_d = done_d && (fail_mask_q == '0);
   end

   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign pass_o          = pass_q;
   assign fail_mask_o     = fail_mask_q;
   assign first_fail_o    = first_fail_q;
   assign mismatch_data_o = mismatch_q;
   assign cycle_cnt_o     = cycle_q;

endmodule
